rtc_timekeeper: RTL and testbench

Parametrised time-of-day core: prescaler, seconds/minutes/hours chain, run/stop, validated time load over a valid/ready handshake, per-field manual increment, and 12/24-hour display conversion. It replaces the fixed 16-bit-prescaler counter chain in the top level. Outputs feed the segment display path and downstream date/alarm logic via one-cycle carry pulses.

---
 rtl/rtc_timekeeper_if.sv | 19 +
 rtl/rtc_timekeeper.sv | 192 +++++++++++++++++++
 tb/tb_rtc_timekeeper.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_timekeeper_if.sv
// Time-load handshake bundle for rtc_timekeeper: valid/ready request, field values, reject pulse.
interface rtc_timekeeper_if;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hour;
  logic [5:0] set_minute;
  logic [5:0] set_second;
  logic       set_err;

  modport master (
    output set_valid, set_hour, set_minute, set_second,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_hour, set_minute, set_second,
    output set_ready, set_err
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// Time-of-day core: prescaler, h:m:s chain with carry pulses, validated load, manual increment,
// 12/24h display. Optional sticky alarm enabled by defining RTC_ALARM_EN.
module rtc_timekeeper #(
  parameter int unsigned TICKS_PER_SEC = 65536,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              mode_12h,
  rtc_timekeeper_if.slave   set_bus,
  input  logic              inc_pulse,
  input  logic [1:0]        inc_sel,
  output logic [5:0]        second,
  output logic [5:0]        minute,
  output logic [4:0]        hour,
  output logic [4:0]        hour_disp,
  output logic              pm,
  output logic              sec_tick,
  output logic              min_tick,
  output logic              hour_tick,
  output logic              day_tick,
  input  logic [4:0]        alarm_hour,
  input  logic [5:0]        alarm_minute,
  input  logic              alarm_arm,
  input  logic              alarm_ack,
  output logic              alarm
);

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TICKS_PER_SEC - 1);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             sec_tick_q, min_tick_q, hour_tick_q, day_tick_q;
  logic             set_err_q, alarm_q, alarm_d;
  logic             load_ok, load_acc, load_rej, inc_acc, at_term;
  logic             sec_adv, sec_wrap, min_wrap, hour_wrap;

  assign load_ok = (set_bus.set_hour <= 5'd23) && (set_bus.set_minute <= 6'd59) &&
                   (set_bus.set_second <= 6'd59);

  // Load handshake: one accepted load per IDLE->ACK->IDLE round trip.
  always_comb begin
    state_d  = state_q;
    load_acc = 1'b0;
    load_rej = 1'b0;
    case (state_q)
      StIdle: begin
        if (set_bus.set_valid) begin
          if (load_ok) begin
            load_acc = 1'b1;
            state_d  = StAck;
          end else begin
            load_rej = 1'b1;
          end
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    presc_d   = presc_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    sec_adv   = 1'b0;
    sec_wrap  = 1'b0;
    min_wrap  = 1'b0;
    hour_wrap = 1'b0;
    inc_acc   = inc_pulse && (inc_sel != 2'b00) && !load_acc;
    at_term   = (presc_q == TermCnt);
    if (load_acc) begin
      presc_d = '0;
      sec_d   = set_bus.set_second;
      min_d   = set_bus.set_minute;
      hour_d  = set_bus.set_hour;
    end else begin
      if (inc_acc) begin
        case (inc_sel)
          2'b01:   sec_d  = (sec_q == 6'd59)  ? 6'd0 : sec_q + 6'd1;
          2'b10:   min_d  = (min_q == 6'd59)  ? 6'd0 : min_q + 6'd1;
          2'b11:   hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          default: ;
        endcase
      end
      // An increment landing on terminal count stalls the prescaler so the second is deferred.
      if (run && !(inc_acc && at_term)) begin
        if (at_term) begin
          presc_d = '0;
          sec_adv = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d    = 6'd0;
            sec_wrap = 1'b1;
            if (min_q == 6'd59) begin
              min_d    = 6'd0;
              min_wrap = 1'b1;
              if (hour_q == 5'd23) begin
                hour_d    = 5'd0;
                hour_wrap = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_hit;
  assign alarm_hit = sec_adv && alarm_arm && (sec_d == 6'd0) && (min_d == alarm_minute) &&
                     (hour_d == alarm_hour);

  always_comb begin
    alarm_d = alarm_q;
    if (alarm_ack || !alarm_arm) begin
      alarm_d = 1'b0;
    end else if (alarm_hit) begin
      alarm_d = 1'b1;
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hour, alarm_minute, alarm_arm, alarm_ack};
  assign alarm_d      = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_tick_q  <= sec_adv;
      min_tick_q  <= sec_wrap;
      hour_tick_q <= min_wrap;
      day_tick_q  <= hour_wrap;
      set_err_q   <= load_rej;
      alarm_q     <= alarm_d;
    end
  end

  always_comb begin
    hour_disp = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour_q > 5'd12) begin
        hour_disp = hour_q - 5'd12;
      end
    end
  end

  assign pm                = (hour_q >= 5'd12);
  assign second            = sec_q;
  assign minute            = min_q;
  assign hour              = hour_q;
  assign sec_tick          = sec_tick_q;
  assign min_tick          = min_tick_q;
  assign hour_tick         = hour_tick_q;
  assign day_tick          = day_tick_q;
  assign alarm             = alarm_q;
  assign set_bus.set_ready = (state_q == StIdle);
  assign set_bus.set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper: seconds-of-day reference model, per-cycle expected state.
module tb_rtc_timekeeper;
  localparam int unsigned Tps = 4;

  logic       clock, reset, run, mode_12h, inc_pulse;
  logic [1:0] inc_sel;
  logic [5:0] second, minute, alarm_minute;
  logic [4:0] hour, hour_disp, alarm_hour;
  logic       pm, sec_tick, min_tick, hour_tick, day_tick, alarm_arm, alarm_ack, alarm;

  rtc_timekeeper_if set_bus ();

  rtc_timekeeper #(.TICKS_PER_SEC(Tps), .CNT_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .mode_12h     (mode_12h),
    .set_bus      (set_bus),
    .inc_pulse    (inc_pulse),
    .inc_sel      (inc_sel),
    .second       (second),
    .minute       (minute),
    .hour         (hour),
    .hour_disp    (hour_disp),
    .pm           (pm),
    .sec_tick     (sec_tick),
    .min_tick     (min_tick),
    .hour_tick    (hour_tick),
    .day_tick     (day_tick),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .alarm_arm    (alarm_arm),
    .alarm_ack    (alarm_ack),
    .alarm        (alarm)
  );

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [4:0] disp;
    logic       pm, st, mt, ht, dt, ready, err, alarm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int   m_tod, m_presc;
  bit   m_ack, m_alarm;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compares the DUT state after each edge against the queued expectation.
  always begin
    exp_t e, g;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {second, minute, hour, hour_disp, pm, sec_tick, min_tick, hour_tick, day_tick,
           set_bus.set_ready, set_bus.set_err, alarm};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL state t=%0t got %0d:%0d:%0d disp=%0d flags=%b exp %0d:%0d:%0d disp=%0d flags=%b",
                 $time, g.hr, g.min, g.sec, g.disp, g[7:0], e.hr, e.min, e.sec, e.disp, e[7:0]);
      end
    end
  end

  function automatic exp_t snapshot(bit st, bit mt, bit ht, bit dt, bit err);
    exp_t e;
    int   h;
    h       = m_tod / 3600;
    e.sec   = 6'(m_tod % 60);
    e.min   = 6'((m_tod / 60) % 60);
    e.hr    = 5'(h);
    e.disp  = mode_12h ? 5'((h % 12 == 0) ? 12 : h % 12) : 5'(h);
    e.pm    = (h >= 12);
    e.st    = st;
    e.mt    = mt;
    e.ht    = ht;
    e.dt    = dt;
    e.ready = !m_ack;
    e.err   = err;
    e.alarm = m_alarm;
    return e;
  endfunction

  task automatic idle();
    set_bus.set_valid = 1'b0;
    inc_pulse         = 1'b0;
    inc_sel           = 2'b00;
    alarm_ack         = 1'b0;
  endtask

  task automatic set_load(int h, int m, int s);
    set_bus.set_valid  = 1'b1;
    set_bus.set_hour   = 5'(h);
    set_bus.set_minute = 6'(m);
    set_bus.set_second = 6'(s);
  endtask

  // Apply the model for the coming edge with current inputs, queue the result, advance.
  task automatic cycle();
    bit load = 0, nack = 0, err = 0, adv = 0, inc_acc;
    bit mt = 0, ht = 0, dt = 0;
    int h, m, s;
    if (!m_ack && set_bus.set_valid) begin
      if (set_bus.set_hour < 24 && set_bus.set_minute < 60 && set_bus.set_second < 60) begin
        load    = 1;
        nack    = 1;
        m_tod   = set_bus.set_hour * 3600 + set_bus.set_minute * 60 + set_bus.set_second;
        m_presc = 0;
      end else begin
        err = 1;
      end
    end
    m_ack   = nack;
    inc_acc = !load && inc_pulse && (inc_sel != 2'b00);
    if (inc_acc) begin
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      if (inc_sel == 2'b01) s = (s + 1) % 60;
      if (inc_sel == 2'b10) m = (m + 1) % 60;
      if (inc_sel == 2'b11) h = (h + 1) % 24;
      m_tod = h * 3600 + m * 60 + s;
    end
    if (!load && run) begin
      if (m_presc == Tps - 1) begin
        if (!inc_acc) begin
          m_presc = 0;
          m_tod   = (m_tod + 1) % 86400;
          adv     = 1;
          mt      = (m_tod % 60 == 0);
          ht      = (m_tod % 3600 == 0);
          dt      = (m_tod == 0);
        end
      end else begin
        m_presc++;
      end
    end
`ifdef RTC_ALARM_EN
    if (alarm_ack || !alarm_arm) m_alarm = 0;
    else if (adv && m_tod == alarm_hour * 3600 + alarm_minute * 60) m_alarm = 1;
`endif
    sb.push_back(snapshot(adv, mt, ht, dt, err));
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    m_tod   = 0;
    m_presc = 0;
    m_ack   = 0;
    m_alarm = 0;
    sb.push_back(snapshot(0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int hrs[4] = '{0, 12, 13, 23};
    reset        = 1'b1;
    run          = 1'b0;
    mode_12h     = 1'b0;
    alarm_arm    = 1'b0;
    alarm_hour   = 5'd0;
    alarm_minute = 6'd0;
    set_bus.set_hour   = 5'd0;
    set_bus.set_minute = 6'd0;
    set_bus.set_second = 6'd0;
    idle();
    @(negedge clock);
    do_reset();

    // Free run past the first minute rollover.
    run = 1'b1;
    repeat (250) cycle();

    // Midnight rollover.
    set_load(23, 59, 58);
    cycle();
    idle();
    repeat (10) cycle();

    // Out-of-range loads.
    set_load(24, 0, 0);
    cycle();
    set_load(0, 60, 0);
    cycle();
    set_load(0, 0, 60);
    cycle();
    idle();
    cycle();

    // 12/24h display.
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 4; i++) begin
        mode_12h = md[0];
        set_load(hrs[i], 30, 0);
        cycle();
        idle();
        repeat (2) cycle();
      end
    end
    mode_12h = 1'b0;

    // Stopped clock and manual increments.
    set_load(5, 59, 30);
    cycle();
    idle();
    run = 1'b0;
    repeat (20) cycle();
    for (int sel = 0; sel < 4; sel++) begin
      inc_pulse = 1'b1;
      inc_sel   = 2'(sel);
      cycle();
      idle();
      cycle();
    end
    set_load(23, 0, 59);
    cycle();
    idle();
    inc_pulse = 1'b1;
    inc_sel   = 2'b11;
    cycle();
    inc_sel   = 2'b01;
    cycle();
    idle();

    // Increment on terminal count defers the second.
    run = 1'b1;
    for (int k = 0; k < 8 && m_presc != Tps - 1; k++) cycle();
    inc_pulse = 1'b1;
    inc_sel   = 2'b10;
    cycle();
    idle();
    repeat (6) cycle();

    // Alarm at 07:30.
    alarm_arm    = 1'b1;
    alarm_hour   = 5'd7;
    alarm_minute = 6'd30;
    set_load(7, 29, 59);
    cycle();
    idle();
    repeat (8) cycle();
    alarm_ack = 1'b1;
    cycle();
    idle();
    repeat (3) cycle();

    // Reset while the load handshake is in ACK.
    set_load(12, 0, 0);
    cycle();
    set_bus.set_valid = 1'b0;
    do_reset();
    run = 1'b1;
    repeat (3) cycle();

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      run                = ($urandom_range(0, 9) != 0);
      mode_12h           = $urandom_range(0, 1);
      set_bus.set_valid  = ($urandom_range(0, 24) == 0);
      set_bus.set_hour   = 5'($urandom_range(0, 25));
      set_bus.set_minute = 6'($urandom_range(0, 61));
      set_bus.set_second = 6'($urandom_range(55, 63));
      inc_pulse          = ($urandom_range(0, 14) == 0);
      inc_sel            = 2'($urandom_range(0, 3));
      alarm_arm          = ($urandom_range(0, 19) != 0);
      alarm_ack          = ($urandom_range(0, 29) == 0);
      alarm_hour         = 5'(m_tod / 3600);
      alarm_minute       = 6'((m_tod / 60) % 60 + $urandom_range(0, 1));
      if (n == 1700) begin
        do_reset();
      end else begin
        cycle();
      end
    end
    idle();

    // Reset mid-count.
    run = 1'b1;
    repeat (5) cycle();
    do_reset();

    repeat (2) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
